uart_tx_engine: RTL

//  UART transmit engine directly downstream of the UART register block.

---
 rtl/uart_tx_engine.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
//
// Purpose:
//   UART transmit engine sitting behind the UART register block. Accepts
//   single-cycle byte writes, buffers them, and serialises each byte onto txd
//   as an 8-bit frame with optional even/odd parity and one or two stop bits,
//   LSB first. Reports busy / buffer / overflow status for the TX status word.
//
// Configuration macro:
//   UART_TX_FIFO_EN  defined   -> circular FIFO of FIFO_DEPTH bytes
//                    undefined -> single holding register (FIFO_DEPTH ignored)
//
// Parameters:
//   FIFO_DEPTH    TX FIFO entries; power of two, >= 2, <= 255
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   divider       clk cycles per bit; 0 stalls the transmitter
//   tx_en         1 = frames may start; 0 = finish current frame, then hold
//   parity_en     1 = append parity bit
//   parity_odd    1 = odd parity, 0 = even
//   stop2         1 = two stop bits, 0 = one
//   txdata        byte to send
//   txdata_valid  single-cycle write strobe for txdata
//   status_clr    pulse clearing the sticky overflow flag
//   txd           serial output, idle high
//   tx_busy       1 while a frame is on the line
//   fifo_level    bytes queued, excluding the frame in flight
//   txstatus      {16'h0, fifo_level, 4'h0, overflow, full, empty, tx_busy}
// -----------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] divider,
  input  logic        tx_en,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic        stop2,
  input  logic [7:0]  txdata,
  input  logic        txdata_valid,
  input  logic        status_clr,
  output logic        txd,
  output logic        tx_busy,
  output logic [7:0]  fifo_level,
  output logic [31:0] txstatus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Frame settings captured when a frame starts; the live inputs may change
  // freely while the frame is on the line.
  typedef struct packed {
    logic [31:0] div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
  } frame_cfg_t;

  // ---------------------------------------------------------------------------
  // Buffer bookkeeping shared by both buffer styles
  // ---------------------------------------------------------------------------
  logic [7:0] r_level;
  logic       r_overflow;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;

  assign w_empty = (r_level == 8'd0);

  // Fullness is judged on the registered level only, so a pop in the same
  // cycle never makes room for the incoming byte.
  assign w_push = txdata_valid && !w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level    <= 8'd0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 8'd1;
        2'b01:   r_level <= r_level - 8'd1;
        default: r_level <= r_level;
      endcase
      // A fresh overflow outranks a simultaneous clear.
      if (txdata_valid && w_full) begin
        r_overflow <= 1'b1;
      end else if (status_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  assign w_full = (r_level == 8'(FIFO_DEPTH));
  assign w_head = r_mem[r_rd_ptr];

  // Pointers are exactly log2(depth) bits, so they wrap modulo depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: storage is deliberately left unreset; the level and pointers alone
  // define which entries are valid, and skipping reset keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= txdata;
    end
  end
`else
  // One-entry holding register; FIFO_DEPTH plays no part in its sizing.
  localparam int HOLD_DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;

  logic [7:0] r_hold;

  assign w_full = (r_level == 8'(HOLD_DEPTH));
  assign w_head = r_hold;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_hold <= txdata;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t      r_state;
  frame_cfg_t  r_cfg;
  logic [31:0] r_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_byte;
  logic        r_stop_second;
  logic        r_txd;
  logic        r_busy;

  logic w_start_ok;
  logic w_bit_done;
  logic w_last_stop;
  logic w_parity;

  assign w_start_ok  = !w_empty && tx_en && (divider != 32'd0);
  assign w_bit_done  = (r_timer == 32'd0);
  assign w_last_stop = !r_cfg.stop2 || r_stop_second;
  assign w_parity    = r_cfg.parity_odd ? ~^r_byte : ^r_byte;

  // A frame starts from IDLE, or straight out of the final stop bit so that
  // queued bytes go out with no idle gap between frames.
  assign w_pop = w_start_ok &&
                 ((r_state == IDLE) ||
                  (r_state == STOP && w_bit_done && w_last_stop));

  // NOTE: every state register below uses non-blocking assignment so all of
  // them update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cfg         <= '0;
      r_timer       <= 32'd0;
      r_bit_idx     <= 3'd0;
      r_byte        <= 8'd0;
      r_stop_second <= 1'b0;
      r_txd         <= 1'b1;
      r_busy        <= 1'b0;
    end else if (w_pop) begin
      r_state       <= START;
      r_cfg         <= '{div:        divider,
                         parity_en:  parity_en,
                         parity_odd: parity_odd,
                         stop2:      stop2};
      r_timer       <= divider - 32'd1;
      r_bit_idx     <= 3'd0;
      r_byte        <= w_head;
      r_stop_second <= 1'b0;
      r_txd         <= 1'b0;
      r_busy        <= 1'b1;
    end else if (r_state != IDLE) begin
      if (!w_bit_done) begin
        r_timer <= r_timer - 32'd1;
      end else begin
        // Every bit, whatever its kind, lasts exactly the latched divider.
        r_timer <= r_cfg.div - 32'd1;
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_bit_idx <= 3'd0;
            r_txd     <= r_byte[0];
          end
          DATA: begin
            if (r_bit_idx == 3'd7) begin
              if (r_cfg.parity_en) begin
                r_state <= PARITY;
                r_txd   <= w_parity;
              end else begin
                r_state <= STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_byte[r_bit_idx + 3'd1];
            end
          end
          PARITY: begin
            r_state <= STOP;
            r_txd   <= 1'b1;
          end
          STOP: begin
            if (!w_last_stop) begin
              r_stop_second <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
            r_txd <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign txd        = r_txd;
  assign tx_busy    = r_busy;
  assign fifo_level = r_level;
  assign txstatus   = {16'h0, r_level, 4'h0, r_overflow, w_full, w_empty, r_busy};

endmodule
